// File: rtl/seq_trigger_mc.sv
// Multi-channel MIDI sequencer trigger: channel-qualified byte FIFO feeding the synth
// controller, plus data_ready / midi_send_byte pulses. Optional macro: SEQ_TRIG_OVF_CNT_EN.
module seq_trigger_mc #(
  parameter int FIFO_DEPTH = 8,
  parameter int TRIG_DLY   = 2,
  parameter int SEND_DLY   = 2
) (
  input  logic        data_clk,
  input  logic        reset_reg_N,
  input  logic        byteready,
  input  logic [3:0]  midi_ch,
  input  logic [7:0]  midibyte_nr,
  input  logic [7:0]  midi_in_data,
  input  logic [15:0] ch_mask,
  input  logic        is_st_sysex,
  input  logic        syx_cmd,
  input  logic        dec_sysex_data_patch_send,
  input  logic        auto_syx_cmd,
  input  logic        seq_ready,
  input  logic        ovf_clr,
  output logic        seq_trigger,
  output logic [3:0]  cur_midi_ch,
  output logic [7:0]  midi_bytes,
  output logic [7:0]  seq_databyte,
  output logic        is_data_byte,
  output logic        is_velocity,
  output logic        data_ready,
  output logic        midi_send_byte,
  output logic        fifo_empty,
  output logic        fifo_full,
  output logic        fifo_ovf,
`ifdef SEQ_TRIG_OVF_CNT_EN
  output logic [7:0]  ovf_count,
`endif
  output logic        issue_state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [19:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop, drop, wr_en;
  logic [19:0]     head;
  logic            seq_trigger_q, data_ready_q, midi_send_q, fifo_ovf_q;
  logic [3:0]      cur_ch_q;
  logic [7:0]      midi_bytes_q, databyte_q;
  logic [TRIG_DLY:0] trig_line_q;
  logic [SEND_DLY:0] send_line_q;
  logic [2:0]      syx_sync_q;
  logic            trig_rise, send_rise, syx_rise;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign push       = byteready & (ch_mask[midi_ch] | is_st_sysex);
  assign drop       = push & fifo_full & ~pop;
  assign wr_en      = push & ~drop;
  assign head       = mem_q[rd_ptr_q];

  // Issue FSM: HOLD forces a gap so seq_ready is re-sampled between bytes.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: if (!fifo_empty && seq_ready) begin
        pop     = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  assign trig_rise = trig_line_q[TRIG_DLY-1] & ~trig_line_q[TRIG_DLY];
  assign send_rise = send_line_q[SEND_DLY-1] & ~send_line_q[SEND_DLY];
  assign syx_rise  = syx_sync_q[1] & ~syx_sync_q[2];

  always_ff @(posedge data_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {midi_ch, midibyte_nr, midi_in_data};
  end

  always_ff @(posedge data_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      seq_trigger_q <= 1'b0;
      cur_ch_q      <= '0;
      midi_bytes_q  <= '0;
      databyte_q    <= '0;
      fifo_ovf_q    <= 1'b0;
      trig_line_q   <= '0;
      send_line_q   <= '0;
      syx_sync_q    <= '0;
      data_ready_q  <= 1'b0;
      midi_send_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      seq_trigger_q <= pop;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q     <= rd_ptr_q + AW'(1);
        cur_ch_q     <= head[19:16];
        midi_bytes_q <= head[15:8];
        databyte_q   <= head[7:0];
      end
      // A drop in the same cycle as ovf_clr keeps the flag set.
      if (drop)         fifo_ovf_q <= 1'b1;
      else if (ovf_clr) fifo_ovf_q <= 1'b0;
      trig_line_q  <= {trig_line_q[TRIG_DLY-1:0], seq_trigger_q};
      send_line_q  <= {send_line_q[SEND_DLY-1:0], dec_sysex_data_patch_send & seq_trigger_q};
      syx_sync_q   <= {syx_sync_q[1:0], syx_cmd};
      data_ready_q <= syx_rise | ((dec_sysex_data_patch_send | auto_syx_cmd) & trig_rise);
      midi_send_q  <= send_rise;
    end
  end

`ifdef SEQ_TRIG_OVF_CNT_EN
  logic [7:0] ovf_cnt_q;
  always_ff @(posedge data_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      ovf_cnt_q <= '0;
    end else if (drop) begin
      if (ovf_cnt_q != 8'hFF) ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end else if (ovf_clr) begin
      ovf_cnt_q <= '0;
    end
  end
  assign ovf_count = ovf_cnt_q;
`endif

  assign seq_trigger     = seq_trigger_q;
  assign cur_midi_ch     = cur_ch_q;
  assign midi_bytes      = midi_bytes_q;
  assign seq_databyte    = databyte_q;
  assign is_data_byte    = midi_bytes_q[0];
  assign is_velocity     = ~midi_bytes_q[0] & (midi_bytes_q != 8'd0);
  assign data_ready      = data_ready_q;
  assign midi_send_byte  = midi_send_q;
  assign fifo_ovf        = fifo_ovf_q;
  assign issue_state_dbg = state_q;

endmodule

// File: tb/tb_seq_trigger_mc.sv
// Bench for seq_trigger_mc: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_seq_trigger_mc;

  localparam int DEPTH    = 8;
  localparam int TRIG_DLY = 2;
  localparam int SEND_DLY = 2;

  // Handshake: a byte is offered when byteready is high for one cycle; it is taken
  // by the consumer one entry per seq_trigger pulse while seq_ready is high.

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        byteready = 0, is_st_sysex = 0, syx_cmd = 0, dec_send = 0, auto_syx = 0;
  logic        seq_ready = 0, ovf_clr = 0;
  logic [3:0]  midi_ch = 0;
  logic [7:0]  midibyte_nr = 0, midi_in_data = 0;
  logic [15:0] ch_mask = 0;

  logic        seq_trigger, is_data_byte, is_velocity, data_ready, midi_send_byte;
  logic        fifo_empty, fifo_full, fifo_ovf, issue_state_dbg;
  logic [3:0]  cur_midi_ch;
  logic [7:0]  midi_bytes, seq_databyte;
`ifdef SEQ_TRIG_OVF_CNT_EN
  logic [7:0]  ovf_count;
`endif

  seq_trigger_mc #(.FIFO_DEPTH(DEPTH), .TRIG_DLY(TRIG_DLY), .SEND_DLY(SEND_DLY)) dut (
    .data_clk(clk), .reset_reg_N(rst_n), .byteready(byteready), .midi_ch(midi_ch),
    .midibyte_nr(midibyte_nr), .midi_in_data(midi_in_data), .ch_mask(ch_mask),
    .is_st_sysex(is_st_sysex), .syx_cmd(syx_cmd), .dec_sysex_data_patch_send(dec_send),
    .auto_syx_cmd(auto_syx), .seq_ready(seq_ready), .ovf_clr(ovf_clr),
    .seq_trigger(seq_trigger), .cur_midi_ch(cur_midi_ch), .midi_bytes(midi_bytes),
    .seq_databyte(seq_databyte), .is_data_byte(is_data_byte), .is_velocity(is_velocity),
    .data_ready(data_ready), .midi_send_byte(midi_send_byte), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_ovf(fifo_ovf),
`ifdef SEQ_TRIG_OVF_CNT_EN
    .ovf_count(ovf_count),
`endif
    .issue_state_dbg(issue_state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- scoreboard / counters ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [19:0] exp_q[$];
  logic        e_trig = 0, e_dr = 0, e_send = 0, e_ovf = 0;
  logic [3:0]  e_ch = 0;
  logic [7:0]  e_nr = 0, e_data = 0, e_cnt = 0;
  logic [7:0]  trig_h = 0, dt_h = 0, syx_h = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      e_trig = 0; e_dr = 0; e_send = 0; e_ovf = 0; e_cnt = 0;
      e_ch = 0; e_nr = 0; e_data = 0;
      trig_h = 0; dt_h = 0; syx_h = 0;
    end else begin
      bit can, acc, drop;
      logic [19:0] hd;
      can  = !e_trig && exp_q.size() > 0 && seq_ready;
      acc  = byteready && (ch_mask[midi_ch] || is_st_sysex);
      drop = acc && exp_q.size() == DEPTH && !can;
      // History bit i holds the value seen i+1 cycles before the new cycle.
      trig_h = {trig_h[6:0], e_trig};
      dt_h   = {dt_h[6:0], dec_send & e_trig};
      syx_h  = {syx_h[6:0], syx_cmd};
      e_dr   = (syx_h[2] & ~syx_h[3]) | ((dec_send | auto_syx) & trig_h[TRIG_DLY]);
      e_send = dt_h[SEND_DLY];
      if (can) begin
        hd = exp_q.pop_front();
        e_ch = hd[19:16]; e_nr = hd[15:8]; e_data = hd[7:0];
      end
      if (acc && !drop) exp_q.push_back({midi_ch, midibyte_nr, midi_in_data});
      if (drop) begin
        e_ovf = 1;
        if (e_cnt != 8'hFF) e_cnt = e_cnt + 1;
      end else if (ovf_clr) begin
        e_ovf = 0;
        e_cnt = 0;
      end
      e_trig = can;
    end
  end

  // ---------------- compare process + event logs ----------------
  logic [19:0] trig_log[$];
  int          trig_cyc[$], dr_cyc[$], send_cyc[$];
  logic        vel_log[$];

  initial begin
    forever begin
      @(posedge clk);
      #3;
      chk("seq_trigger", seq_trigger, e_trig);
      chk("cur_midi_ch", cur_midi_ch, e_ch);
      chk("midi_bytes", midi_bytes, e_nr);
      chk("seq_databyte", seq_databyte, e_data);
      chk("is_data_byte", is_data_byte, e_nr % 2);
      chk("is_velocity", is_velocity, (e_nr != 0) && (e_nr % 2 == 0));
      chk("data_ready", data_ready, e_dr);
      chk("midi_send_byte", midi_send_byte, e_send);
      chk("fifo_empty", fifo_empty, exp_q.size() == 0);
      chk("fifo_full", fifo_full, exp_q.size() == DEPTH);
      chk("fifo_ovf", fifo_ovf, e_ovf);
`ifdef SEQ_TRIG_OVF_CNT_EN
      chk("ovf_count", ovf_count, e_cnt);
`endif
      if (seq_trigger) begin
        trig_log.push_back({cur_midi_ch, midi_bytes, seq_databyte});
        trig_cyc.push_back(cyc);
        vel_log.push_back(is_velocity);
      end
      if (data_ready) dr_cyc.push_back(cyc);
      if (midi_send_byte) send_cyc.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    trig_log.delete(); trig_cyc.delete(); vel_log.delete();
    dr_cyc.delete(); send_cyc.delete();
  endtask

  // Called right after a falling edge; returns one cycle later with byteready low.
  task automatic push_byte(input logic [3:0] ch, input logic [7:0] nr, input logic [7:0] d);
    byteready = 1; midi_ch = ch; midibyte_nr = nr; midi_in_data = d;
    @(negedge clk);
    byteready = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  int n0;

  initial begin
    #1 rst_n = 0;
    wait_cycles(3);
    chk("reset_fifo_empty", fifo_empty, 1);
    chk("reset_seq_trigger", seq_trigger, 0);
    chk("reset_data_ready", data_ready, 0);
    rst_n = 1;
    wait_cycles(2);

    // Channel filter: only the ch2 note-on is accepted.
    ch_mask = 16'h0004; seq_ready = 1;
    clear_logs();
    push_byte(2, 0, 8'h90); push_byte(2, 1, 8'h3C); push_byte(2, 2, 8'h64);
    push_byte(5, 0, 8'h90); push_byte(5, 1, 8'h40); push_byte(5, 2, 8'h7F);
    wait_cycles(20);
    chk("t1_count", trig_log.size(), 3);
    if (trig_log.size() == 3) begin
      chk("t1_b0", trig_log[0], {4'd2, 8'd0, 8'h90});
      chk("t1_b1", trig_log[1], {4'd2, 8'd1, 8'h3C});
      chk("t1_b2", trig_log[2], {4'd2, 8'd2, 8'h64});
      chk("t1_vel", {vel_log[0], vel_log[1], vel_log[2]}, 3'b001);
    end

    // Sysex bypasses the channel mask; trigger two cycles after the push.
    ch_mask = 16'h0000; is_st_sysex = 1;
    clear_logs();
    n0 = cyc;
    push_byte(7, 0, 8'hF0);
    wait_cycles(6);
    is_st_sysex = 0;
    chk("t2_count", trig_log.size(), 1);
    if (trig_log.size() == 1) begin
      chk("t2_latency", trig_cyc[0] - n0, 2);
      chk("t2_data", trig_log[0][7:0], 8'hF0);
    end

    // Overflow: nine pushes into an 8-deep FIFO with the consumer stalled.
    ch_mask = 16'h0004; seq_ready = 0;
    clear_logs();
    for (int i = 0; i < 9; i++) push_byte(2, 8'(i), 8'(8'h10 + i));
    chk("t3_full", fifo_full, 1);
    chk("t3_ovf", fifo_ovf, 1);
`ifdef SEQ_TRIG_OVF_CNT_EN
    chk("t3_ovf_count", ovf_count, 1);
`endif
    seq_ready = 1;
    wait_cycles(25);
    chk("t3_count", trig_log.size(), 8);
    if (trig_log.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("t3_order", trig_log[i][7:0], 8'(8'h10 + i));
      for (int i = 1; i < 8; i++) chk("t3_spacing", trig_cyc[i] - trig_cyc[i-1], 2);
    end
    chk("t3_drained", fifo_empty, 1);
    ovf_clr = 1;
    wait_cycles(1);
    ovf_clr = 0;
    chk("t3_ovf_clr", fifo_ovf, 0);

    // Patch-send path: one issued byte gives one midi_send_byte and one data_ready.
    dec_send = 1;
    clear_logs();
    push_byte(2, 1, 8'h55);
    wait_cycles(12);
    chk("t4_trig", trig_log.size(), 1);
    chk("t4_send_n", send_cyc.size(), 1);
    chk("t4_dr_n", dr_cyc.size(), 1);
    if (trig_log.size() == 1 && send_cyc.size() == 1 && dr_cyc.size() == 1) begin
      chk("t4_send_dly", send_cyc[0] - trig_cyc[0], 3);
      chk("t4_dr_dly", dr_cyc[0] - trig_cyc[0], 3);
    end
    dec_send = 0;
    wait_cycles(2);

    // syx_cmd held high: a single data_ready three cycles after the rise.
    clear_logs();
    n0 = cyc;
    syx_cmd = 1;
    wait_cycles(10);
    syx_cmd = 0;
    wait_cycles(6);
    chk("t5_dr_n", dr_cyc.size(), 1);
    if (dr_cyc.size() == 1) chk("t5_dr_dly", dr_cyc[0] - n0, 3);

    // Reset while four entries are buffered and the FSM is in HOLD.
    seq_ready = 0;
    for (int i = 0; i < 5; i++) push_byte(2, 8'(i), 8'(8'hA0 + i));
    seq_ready = 1;
    wait_cycles(1);
    chk("t6_hold", issue_state_dbg, 1);
    chk("t6_trig_pre", seq_trigger, 1);
    rst_n = 0;
    #1;
    chk("t6_rst_trig", seq_trigger, 0);
    chk("t6_rst_empty", fifo_empty, 1);
    chk("t6_rst_data", seq_databyte, 0);
    chk("t6_rst_nr", midi_bytes, 0);
    chk("t6_rst_state", issue_state_dbg, 0);
    wait_cycles(3);
    clear_logs();
    rst_n = 1;
    wait_cycles(12);
    chk("t6_no_trig", trig_log.size(), 0);
    chk("t6_empty", fifo_empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
